// File: rtl/prm_pkg.sv
// Shared constants and FSM encoding for the parameter-memory readout block.
// Defaults for the sweep length and word width, the index and hit-counter
// widths, and the readout FSM state type.
package prm_pkg;

   localparam int NUM_WORDS_DEF = 128;  // 8 banks x 16 words
   localparam int WORD_W_DEF    = 32;
   localparam int IDX_W         = 7;    // {bank[2:0], word[3:0]}
   localparam int HIT_W         = 13;   // holds 128 * 32 = 4096 without wrap
   localparam int POP_W         = 6;    // popcount of one 32-bit word

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/popcount32.sv
// Combinational population count of a 32-bit word.
// Ports:
//   data_i   in  32  word to count
//   count_o  out  6  number of set bits in data_i (0..32)
module popcount32
   import prm_pkg::*;
(
   input  logic [31:0]      data_i,
   output logic [POP_W-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < 32; i++) begin
         count_o = count_o + {{(POP_W-1){1'b0}}, data_i[i]};
      end
   end

endmodule

// File: rtl/prm_rdout_v1_0.sv
// Readout sweeper: walks every {bank, word} address of an upstream edge
// accumulator, captures each combinational word and offers it downstream on a
// valid/ready port, while totalling the set bits of all captured words.
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   start              one-cycle sweep request (ignored unless idle)
//   sel1 / sel2        bank / word-in-bank select to the accumulator
//   result_imp         word returned for the current select
//   m_data/m_idx/m_last/m_valid, m_ready   downstream word port
//   busy, done         sweep in progress / one-cycle completion pulse
//   hit_count          set-bit total of the current (or last) sweep
//   dbg_state_o        current FSM state
//
// Downstream handshake: m_data, m_idx and m_last are meaningful only while
// m_valid is high; a word transfers on a rising edge where m_valid and m_ready
// are both high, and while m_ready is low every m_* output holds unchanged.
module prm_rdout_v1_0
   import prm_pkg::*;
#(
   parameter int NUM_WORDS = NUM_WORDS_DEF,
   parameter int WORD_W    = WORD_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   output logic [2:0]        sel1,
   output logic [7:0]        sel2,
   input  logic [WORD_W-1:0] result_imp,
   output logic [WORD_W-1:0] m_data,
   output logic [IDX_W-1:0]  m_idx,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic [HIT_W-1:0]  hit_count,
   output logic [1:0]        dbg_state_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic [IDX_W-1:0]    midx_q, midx_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic [HIT_W-1:0]    hit_q, hit_d;
   logic [POP_W-1:0]    pop;
   logic [IDX_W-1:0]    sel_idx;

   popcount32 u_popcount32 (
      .data_i  (result_imp),
      .count_o (pop)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         midx_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         midx_q  <= midx_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      midx_d  = midx_q;
      valid_d = valid_q;
      last_d  = last_q;
      hit_d   = hit_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               idx_d   = '0;
               hit_d   = '0;
            end
         end
         ST_LOAD: begin
            // The source keeps accumulating; this is the only sampling point.
            data_d  = result_imp;
            midx_d  = idx_q;
            valid_d = 1'b1;
            last_d  = (idx_q == LAST_IDX);
            hit_d   = hit_q + HIT_W'(pop);
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (m_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               if (last_q) begin
                  state_d = ST_FIN;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_FIN: begin
            // Unconditional return; a start seen here is deliberately dropped.
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sel_idx     = (state_q == ST_LOAD || state_q == ST_SEND) ? idx_q : '0;
   assign sel1        = sel_idx[6:4];
   assign sel2        = {4'b0000, sel_idx[3:0]};
   assign m_data      = data_q;
   assign m_idx       = midx_q;
   assign m_valid     = valid_q;
   assign m_last      = last_q;
   assign hit_count   = hit_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_FIN);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prm_rdout_v1_0.sv
module tb_prm_rdout_v1_0;

   localparam int NW = 128;

   // ---------------- clock / reset / DUT ----------------
   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic        m_ready;
   logic [2:0]  sel1;
   logic [7:0]  sel2;
   logic [31:0] result_imp;
   logic [31:0] m_data;
   logic [6:0]  m_idx;
   logic        m_valid;
   logic        m_last;
   logic        busy;
   logic        done;
   logic [12:0] hit_count;
   logic [1:0]  dbg_state;

   always #5 CLK = ~CLK;

   // Source memory modelling the accumulator: bit b of the sweep lives in
   // word b/32, bit b%32.
   logic [31:0] src [NW];
   assign result_imp = src[{sel1, sel2[3:0]}];

   prm_rdout_v1_0 dut (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start),
      .sel1        (sel1),
      .sel2        (sel2),
      .result_imp  (result_imp),
      .m_data      (m_data),
      .m_idx       (m_idx),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .busy        (busy),
      .done        (done),
      .hit_count   (hit_count),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fill_src(input logic [31:0] pat, input int one_bit);
      for (int i = 0; i < NW; i++) src[i] = pat;
      if (one_bit >= 0) src[one_bit / 32] = 32'd1 << (one_bit % 32);
   endtask

   task automatic fill_random();
      for (int i = 0; i < NW; i++) src[i] = $urandom();
   endtask

   // ---------------- driver: one full sweep ----------------
   // Called at a falling edge with the DUT idle. Expected words, indices,
   // hit total and completion cycle come from the source array and the
   // handshake rules: one word per LOAD+SEND pair, plus one per stall cycle.
   task automatic run_sweep(input string tag, input int rdy_pct, input int stall_at,
                            input int restart_at, input bit fin_start, output int done_cyc);
      int cyc, stalls, stall_left, pulses, exp_idx, model_hit;
      bit stall_done, sel_bad, busy_bad, got_done;
      exp_q.delete();
      model_hit = 0;
      for (int i = 0; i < NW; i++) begin
         exp_q.push_back(src[i]);
         model_hit += $countones(src[i]);
      end
      stalls = 0; stall_left = 0; pulses = 0; exp_idx = 0;
      stall_done = 0; sel_bad = 0; busy_bad = 0; got_done = 0; done_cyc = -1;
      start   = 1'b1;
      m_ready = 1'b0;
      @(negedge CLK);
      cyc = 1;
      while (!got_done && cyc < 3000) begin
         start = 1'b0;
         if (sel2[7:4] != 4'd0) sel_bad = 1;
         if (!busy) busy_bad = 1;
         if (done) begin
            got_done = 1;
            done_cyc = cyc;
            pulses++;
            if (fin_start) start = 1'b1;
         end else begin
            if (stall_at >= 0 && !stall_done && stall_left == 0 && m_valid && m_idx == 7'(stall_at))
               stall_left = 5;
            if (stall_left > 0) begin
               m_ready = 1'b0;
               chk({tag, " stall valid"}, 32'(m_valid), 32'd1);
               chk({tag, " stall data"}, m_data, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
               chk({tag, " stall idx"}, 32'(m_idx), 32'(exp_idx));
               stall_left--;
               if (stall_left == 0) stall_done = 1;
            end else begin
               m_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            if (m_valid && !m_ready) stalls++;
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  chk({tag, " extra word"}, 32'(m_idx), 32'hFFFF_FFFF);
               end else begin
                  chk({tag, " data"}, m_data, exp_q.pop_front());
                  chk({tag, " idx"}, 32'(m_idx), 32'(exp_idx));
                  chk({tag, " last"}, 32'(m_last), 32'(exp_idx == NW - 1));
                  exp_idx++;
               end
            end
            if (restart_at >= 0 && m_valid && m_idx == 7'(restart_at)) start = 1'b1;
         end
         @(negedge CLK);
         cyc++;
      end
      start = 1'b0;
      chk({tag, " done seen"}, 32'(got_done), 32'd1);
      chk({tag, " words left"}, 32'(exp_q.size()), 32'd0);
      chk({tag, " done cycle"}, 32'(done_cyc), 32'(2 * NW + 1 + stalls));
      chk({tag, " hit_count"}, 32'(hit_count), 32'(model_hit));
      chk({tag, " sel2 hi zero"}, 32'(sel_bad), 32'd0);
      chk({tag, " busy during sweep"}, 32'(busy_bad), 32'd0);
      for (int k = 0; k < 3; k++) begin
         if (done) pulses++;
         chk({tag, " idle busy"}, 32'(busy), 32'd0);
         @(negedge CLK);
      end
      chk({tag, " done pulses"}, 32'(pulses), 32'd1);
      chk({tag, " hit hold"}, 32'(hit_count), 32'(model_hit));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] fill;
      int          one_bit;
      int          exp_hit;
      int          exp_done;
   } vec_t;

   vec_t vecs [5];

   task automatic chk_all_zero(input string tag);
      chk({tag, " sel1"}, 32'(sel1), 32'd0);
      chk({tag, " sel2"}, 32'(sel2), 32'd0);
      chk({tag, " m_data"}, m_data, 32'd0);
      chk({tag, " m_idx"}, 32'(m_idx), 32'd0);
      chk({tag, " m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, " m_last"}, 32'(m_last), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " hit_count"}, 32'(hit_count), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int dc;
      bit found;
      vecs[0] = '{32'h0000_0000, -1,    0, 257};
      vecs[1] = '{32'hFFFF_FFFF, -1, 4096, 257};
      vecs[2] = '{32'h0000_0000, 1000,  1, 257};
      vecs[3] = '{32'h0000_000F, -1,  512, 257};
      vecs[4] = '{32'h8000_0001, -1,  256, 257};

      RST = 1'b1; start = 1'b0; m_ready = 1'b0;
      fill_src(32'h0, -1);
      repeat (3) @(negedge CLK);
      chk_all_zero("reset");
      RST = 1'b0;

      // Start on the very first edge after reset release.
      for (int t = 0; t < 5; t++) begin
         fill_src(vecs[t].fill, vecs[t].one_bit);
         run_sweep($sformatf("vec%0d", t), 100, -1, -1, 1'b0, dc);
         chk($sformatf("vec%0d table hit", t), 32'(hit_count), 32'(vecs[t].exp_hit));
         chk($sformatf("vec%0d table done", t), 32'(dc), 32'(vecs[t].exp_done));
      end

      // Five-cycle back-pressure on word 3.
      fill_random();
      run_sweep("stall", 100, 3, -1, 1'b0, dc);
      chk("stall done cycle", 32'(dc), 32'd262);

      // start during the sweep and in the FIN cycle must both be dropped.
      fill_random();
      run_sweep("restart", 100, -1, 10, 1'b1, dc);
      chk("restart done cycle", 32'(dc), 32'd257);

      // Random source and random back-pressure.
      for (int r = 0; r < 3; r++) begin
         fill_random();
         run_sweep($sformatf("rand%0d", r), 55, -1, -1, 1'b0, dc);
      end

      // Reset in the middle of a sweep, then an immediate fresh sweep.
      fill_src(32'hFFFF_FFFF, -1);
      start = 1'b1; m_ready = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      found = 0;
      for (int k = 0; k < 400 && !found; k++) begin
         if (m_valid && m_idx == 7'd60) found = 1;
         else @(negedge CLK);
      end
      chk("rst reach idx60", 32'(found), 32'd1);
      RST = 1'b1;
      #1;
      chk_all_zero("midrst");
      @(negedge CLK);
      RST = 1'b0;
      fill_random();
      run_sweep("after_rst", 100, -1, -1, 1'b0, dc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/prm_rdout_v1_0.md
PRM_RDOUT_V1_0 -- requirements
Module: prm_rdout_v1_0

Interface
REQ-001 Parameter NUM_WORDS, default 128: number of 32-bit words swept per readout (8 banks x 16 words).
REQ-002 Parameter WORD_W, default 32: width of the readout word.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a full readout sweep.
REQ-006 sel1  output  3  bank select to the upstream edge accumulator.
REQ-007 sel2  output  8  word-in-bank select; bits [7:4] always 0.
REQ-008 result_imp  input  32  combinational word returned by the accumulator for the current {sel1,sel2}.
REQ-009 m_data  output  32  captured word.
REQ-010 m_idx  output  7  word index {sel1,sel2[3:0]} of m_data.
REQ-011 m_valid  output  1  m_data/m_idx/m_last valid.
REQ-012 m_ready  input  1  downstream accepts the word when m_valid and m_ready are both high.
REQ-013 m_last  output  1  high with the word at index NUM_WORDS-1.
REQ-014 busy  output  1  high from the cycle after start is accepted until done.
REQ-015 done  output  1  one-cycle pulse after the last word is accepted.
REQ-016 hit_count  output  13  total set bits over all captured words of the current sweep.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SEND, FIN.
REQ-018 IDLE: sel1=0, sel2=0, m_valid=0; on start=1 go to LOAD, clear idx to 0, clear hit_count to 0.
REQ-019 LOAD (one cycle): sel outputs SHALL equal idx; at the clock edge, capture result_imp into m_data, idx into m_idx, set m_valid=1, set m_last=(idx==NUM_WORDS-1), add popcount(result_imp) to hit_count, go to SEND.
REQ-020 SEND: m_valid, m_data, m_idx and m_last SHALL hold stable while m_ready=0.
REQ-021 SEND with m_ready=1: drop m_valid next cycle. If m_last, go to FIN. Otherwise increment idx and go to LOAD.
REQ-022 FIN (one cycle): done=1, busy=0 next cycle, return to IDLE; hit_count holds until the next accepted start.
REQ-023 Throughput SHALL be one word per 2 cycles with m_ready tied high; a full sweep SHALL take 2*NUM_WORDS+1 cycles from start to done.
REQ-024 start while busy SHALL be ignored; start in the same cycle as FIN SHALL be ignored.
REQ-025 Words SHALL be sampled at their LOAD cycle only; the sweep is not an atomic snapshot of the still-accumulating source.
REQ-026 hit_count SHALL NOT wrap: the maximum is 4096, which fits in 13 bits.
REQ-027 idx SHALL never exceed NUM_WORDS-1, and sel2[7:4] SHALL be 0 in every state.

Reset
REQ-028 RST=1 SHALL immediately force IDLE, idx=0, sel1=0, sel2=0, m_data=0, m_idx=0, m_valid=0, m_last=0, busy=0, done=0 and hit_count=0, including in the middle of a sweep.
REQ-029 After RST deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-030 Shared package prm_pkg SHALL hold NUM_WORDS, WORD_W, the idx width (7), the hit_count width (13) and the state encodings.
REQ-031 A combinational sub-module popcount32 (32-bit input, 6-bit count) SHALL compute the per-word bit count.

Verification
REQ-032 Source is all zeros, start, m_ready=1 -> 128 words of 0x00000000; m_last only at m_idx=127; done at cycle 257 after start; hit_count=0.
REQ-033 Source is all ones -> each m_data=0xFFFFFFFF; final hit_count=4096; sel2[7:4]=0 throughout.
REQ-034 Only bit 1000 set (bank 1, word 15, bit 8) -> word m_idx=31 equals 0x00000100, all other words 0; hit_count=1.
REQ-035 m_ready=0 for 5 cycles at m_idx=3 -> m_data, m_idx and m_valid stay stable for those 5 cycles; no word is skipped or duplicated.
REQ-036 RST pulsed at m_idx=60 -> all outputs 0 within the same cycle; a new start sweeps again from m_idx=0 with hit_count restarted at 0.
REQ-037 start re-asserted at m_idx=10 and again in the FIN cycle -> both ignored; exactly one done pulse.
